// File: rtl/imager_tx.sv
// imager_tx: rebuilds a parallel fv/lv/dv sensor-style stream from the dvi/dtypei/datai pipeline.
// Optional test-pattern source is enabled by defining IMAGER_TX_TEST_PAT_EN.

`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif
`ifndef DTYPE_PIXEL
`define DTYPE_PIXEL 4'd0
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 4'd1
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END 4'd2
`endif
`ifndef DTYPE_ROW_START
`define DTYPE_ROW_START 4'd3
`endif
`ifndef DTYPE_ROW_END
`define DTYPE_ROW_END 4'd4
`endif
`ifndef DTYPE_HEADER_START
`define DTYPE_HEADER_START 4'd5
`endif
`ifndef DTYPE_HEADER
`define DTYPE_HEADER 4'd6
`endif
`ifndef DTYPE_HEADER_END
`define DTYPE_HEADER_END 4'd7
`endif

module imager_tx #(
  parameter int PIXEL_WIDTH = 12,
  parameter int DATA_WIDTH  = 16,
  parameter int DIM_WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    resetb,
  input  logic                    enable,
  input  logic                    left_justify,
  input  logic                    dvi,
  input  logic [`DTYPE_WIDTH-1:0] dtypei,
  input  logic [DATA_WIDTH-1:0]   datai,
  input  logic                    err_clr,
`ifdef IMAGER_TX_TEST_PAT_EN
  input  logic                    test_pat,
`endif
  output logic                    fv,
  output logic                    lv,
  output logic                    dvo,
  output logic [PIXEL_WIDTH-1:0]  datao,
  output logic [DIM_WIDTH-1:0]    num_rows,
  output logic [DIM_WIDTH-1:0]    num_cols,
  output logic [15:0]             frame_count,
  output logic                    protocol_err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FRAME = 2'd1;
  localparam logic [1:0] ST_LINE  = 2'd2;

  logic [1:0]             state_reg, state_next;
  logic                   fv_reg, fv_next;
  logic                   lv_reg, lv_next;
  logic                   dvo_reg, dvo_next;
  logic [PIXEL_WIDTH-1:0] datao_reg, datao_next;
  logic [DIM_WIDTH-1:0]   row_cnt_reg, row_cnt_next;
  logic [DIM_WIDTH-1:0]   col_cnt_reg, col_cnt_next;
  logic [DIM_WIDTH-1:0]   last_cols_reg, last_cols_next;
  logic [DIM_WIDTH-1:0]   num_rows_reg, num_rows_next;
  logic [DIM_WIDTH-1:0]   num_cols_reg, num_cols_next;
  logic [15:0]            frame_count_reg, frame_count_next;
  logic                   protocol_err_reg, protocol_err_next;
  logic                   err_now;

  logic [PIXEL_WIDTH-1:0] pix_src;
  logic [PIXEL_WIDTH-1:0] pix_val;

  assign pix_src = left_justify ? datai[DATA_WIDTH-1 -: PIXEL_WIDTH] : datai[PIXEL_WIDTH-1:0];

`ifdef IMAGER_TX_TEST_PAT_EN
  // An implicit row start (PIXEL seen in FRAME) is column 0 of the new row.
  logic [DIM_WIDTH-1:0] pat_sum;
  assign pat_sum = row_cnt_reg + ((state_reg == ST_LINE) ? col_cnt_reg : '0);
  assign pix_val = test_pat ? PIXEL_WIDTH'(pat_sum) : pix_src;
`else
  assign pix_val = pix_src;
`endif

  always_comb begin
    state_next       = state_reg;
    dvo_next         = 1'b0;
    datao_next       = '0;
    row_cnt_next     = row_cnt_reg;
    col_cnt_next     = col_cnt_reg;
    last_cols_next   = last_cols_reg;
    num_rows_next    = num_rows_reg;
    num_cols_next    = num_cols_reg;
    frame_count_next = frame_count_reg;
    err_now          = 1'b0;

    if (dvi) begin
      case (state_reg)
        ST_IDLE: begin
          // enable only gates frame entry, so a frame is never cut short
          if (dtypei == `DTYPE_FRAME_START && enable) begin
            state_next       = ST_FRAME;
            frame_count_next = frame_count_reg + 16'd1;
            row_cnt_next     = '0;
          end
        end
        ST_FRAME: begin
          case (dtypei)
            `DTYPE_FRAME_START, `DTYPE_ROW_END: err_now = 1'b1;
            `DTYPE_ROW_START: begin
              state_next   = ST_LINE;
              col_cnt_next = '0;
            end
            `DTYPE_PIXEL: begin
              state_next   = ST_LINE;
              dvo_next     = 1'b1;
              datao_next   = pix_val;
              col_cnt_next = {{(DIM_WIDTH-1){1'b0}}, 1'b1};
            end
            `DTYPE_FRAME_END: begin
              state_next    = ST_IDLE;
              num_rows_next = row_cnt_reg;
              num_cols_next = last_cols_reg;
            end
            default: ;
          endcase
        end
        ST_LINE: begin
          case (dtypei)
            `DTYPE_FRAME_START, `DTYPE_ROW_START: err_now = 1'b1;
            `DTYPE_PIXEL: begin
              dvo_next     = 1'b1;
              datao_next   = pix_val;
              col_cnt_next = col_cnt_reg + 1'b1;
            end
            `DTYPE_ROW_END: begin
              state_next     = ST_FRAME;
              row_cnt_next   = row_cnt_reg + 1'b1;
              last_cols_next = col_cnt_reg;
            end
            `DTYPE_FRAME_END: begin
              state_next    = ST_IDLE;
              num_rows_next = row_cnt_reg + 1'b1;
              num_cols_next = col_cnt_reg;
            end
            default: ;
          endcase
        end
        default: state_next = ST_IDLE;
      endcase
    end

    fv_next           = (state_next != ST_IDLE);
    lv_next           = (state_next == ST_LINE);
    protocol_err_next = err_now | (protocol_err_reg & ~err_clr);
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_reg        <= ST_IDLE;
      fv_reg           <= 1'b0;
      lv_reg           <= 1'b0;
      dvo_reg          <= 1'b0;
      datao_reg        <= '0;
      row_cnt_reg      <= '0;
      col_cnt_reg      <= '0;
      last_cols_reg    <= '0;
      num_rows_reg     <= '0;
      num_cols_reg     <= '0;
      frame_count_reg  <= '0;
      protocol_err_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      fv_reg           <= fv_next;
      lv_reg           <= lv_next;
      dvo_reg          <= dvo_next;
      datao_reg        <= datao_next;
      row_cnt_reg      <= row_cnt_next;
      col_cnt_reg      <= col_cnt_next;
      last_cols_reg    <= last_cols_next;
      num_rows_reg     <= num_rows_next;
      num_cols_reg     <= num_cols_next;
      frame_count_reg  <= frame_count_next;
      protocol_err_reg <= protocol_err_next;
    end
  end

  assign fv           = fv_reg;
  assign lv           = lv_reg;
  assign dvo          = dvo_reg;
  assign datao        = datao_reg;
  assign num_rows     = num_rows_reg;
  assign num_cols     = num_cols_reg;
  assign frame_count  = frame_count_reg;
  assign protocol_err = protocol_err_reg;

endmodule

// File: tb/tb_imager_tx.sv
// tb_imager_tx: table-driven scoreboard bench for imager_tx, plus an async-reset sequence.

`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif
`ifndef DTYPE_PIXEL
`define DTYPE_PIXEL 4'd0
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 4'd1
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END 4'd2
`endif
`ifndef DTYPE_ROW_START
`define DTYPE_ROW_START 4'd3
`endif
`ifndef DTYPE_ROW_END
`define DTYPE_ROW_END 4'd4
`endif
`ifndef DTYPE_HEADER_START
`define DTYPE_HEADER_START 4'd5
`endif
`ifndef DTYPE_HEADER
`define DTYPE_HEADER 4'd6
`endif
`ifndef DTYPE_HEADER_END
`define DTYPE_HEADER_END 4'd7
`endif

module tb_imager_tx;

  localparam logic [3:0] PX = `DTYPE_PIXEL;
  localparam logic [3:0] FS = `DTYPE_FRAME_START;
  localparam logic [3:0] FE = `DTYPE_FRAME_END;
  localparam logic [3:0] RS = `DTYPE_ROW_START;
  localparam logic [3:0] RE = `DTYPE_ROW_END;
  localparam logic [3:0] HS = `DTYPE_HEADER_START;
  localparam logic [3:0] HD = `DTYPE_HEADER;
  localparam logic [3:0] HE = `DTYPE_HEADER_END;

  logic                    clk = 1'b0;
  logic                    resetb;
  logic                    enable;
  logic                    left_justify;
  logic                    dvi;
  logic [`DTYPE_WIDTH-1:0] dtypei;
  logic [15:0]             datai;
  logic                    err_clr;
  logic                    fv, lv, dvo;
  logic [11:0]             datao;
  logic [15:0]             num_rows, num_cols, frame_count;
  logic                    protocol_err;

  imager_tx #(.PIXEL_WIDTH(12), .DATA_WIDTH(16), .DIM_WIDTH(16)) dut (
    .clk          (clk),
    .resetb       (resetb),
    .enable       (enable),
    .left_justify (left_justify),
    .dvi          (dvi),
    .dtypei       (dtypei),
    .datai        (datai),
    .err_clr      (err_clr),
`ifdef IMAGER_TX_TEST_PAT_EN
    .test_pat     (1'b0),
`endif
    .fv           (fv),
    .lv           (lv),
    .dvo          (dvo),
    .datao        (datao),
    .num_rows     (num_rows),
    .num_cols     (num_cols),
    .frame_count  (frame_count),
    .protocol_err (protocol_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dv;
    logic [3:0]  dt;
    logic [15:0] d;
    logic        en;
    logic        lj;
    logic        clr;
    logic        efv;
    logic        elv;
    logic        edvo;
    logic [11:0] edat;
    logic        eerr;
    logic        chk_cnt;
    int          erows;
    int          ecols;
    int          efc;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(logic dv, logic [3:0] dt, logic [15:0] d, logic en, logic lj,
                              logic clr, logic efv, logic elv, logic edvo, logic [11:0] edat,
                              logic eerr);
    vec_t v;
    v.dv = dv; v.dt = dt; v.d = d; v.en = en; v.lj = lj; v.clr = clr;
    v.efv = efv; v.elv = elv; v.edvo = edvo; v.edat = edat; v.eerr = eerr;
    v.chk_cnt = 1'b0; v.erows = 0; v.ecols = 0; v.efc = 0;
    return v;
  endfunction

  function automatic void mark(int r, int c, int f);
    tbl[tbl.size()-1].chk_cnt = 1'b1;
    tbl[tbl.size()-1].erows   = r;
    tbl[tbl.size()-1].ecols   = c;
    tbl[tbl.size()-1].efc     = f;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, want);
    end
  endtask

  task automatic apply(vec_t v, int idx);
    vec_t e;
    @(negedge clk);
    dvi = v.dv; dtypei = v.dt; datai = v.d;
    enable = v.en; left_justify = v.lj; err_clr = v.clr;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk($sformatf("v%0d.fv", idx), {31'd0, fv}, {31'd0, e.efv});
    chk($sformatf("v%0d.lv", idx), {31'd0, lv}, {31'd0, e.elv});
    chk($sformatf("v%0d.dvo", idx), {31'd0, dvo}, {31'd0, e.edvo});
    chk($sformatf("v%0d.datao", idx), {20'd0, datao}, {20'd0, e.edat});
    chk($sformatf("v%0d.perr", idx), {31'd0, protocol_err}, {31'd0, e.eerr});
    $display("vec %0d dv=%0d dt=%0d d=%h -> fv=%0d lv=%0d dvo=%0d datao=%h err=%0d",
             idx, v.dv, v.dt, v.d, fv, lv, dvo, datao, protocol_err);
    if (e.chk_cnt) begin
      chk($sformatf("v%0d.num_rows", idx), {16'd0, num_rows}, e.erows);
      if (e.ecols >= 0) chk($sformatf("v%0d.num_cols", idx), {16'd0, num_cols}, e.ecols);
      chk($sformatf("v%0d.frame_count", idx), {16'd0, frame_count}, e.efc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Phase 1: 2x3 frame, right-justified, with a dvi=0 bubble mid-line
    tbl.push_back(mk(1, FS, 16'h0000, 1, 0, 0, 1, 0, 0, 12'h000, 0));
    tbl.push_back(mk(1, RS, 16'h0000, 1, 0, 0, 1, 1, 0, 12'h000, 0));
    tbl.push_back(mk(1, PX, 16'h0001, 1, 0, 0, 1, 1, 1, 12'h001, 0));
    tbl.push_back(mk(1, PX, 16'h0002, 1, 0, 0, 1, 1, 1, 12'h002, 0));
    tbl.push_back(mk(0, PX, 16'h0FFF, 1, 0, 0, 1, 1, 0, 12'h000, 0));
    tbl.push_back(mk(1, PX, 16'h0003, 1, 0, 0, 1, 1, 1, 12'h003, 0));
    tbl.push_back(mk(1, RE, 16'h0000, 1, 0, 0, 1, 0, 0, 12'h000, 0));
    tbl.push_back(mk(1, RS, 16'h0000, 1, 0, 0, 1, 1, 0, 12'h000, 0));
    tbl.push_back(mk(1, PX, 16'h0004, 1, 0, 0, 1, 1, 1, 12'h004, 0));
    tbl.push_back(mk(1, PX, 16'h0005, 1, 0, 0, 1, 1, 1, 12'h005, 0));
    tbl.push_back(mk(1, PX, 16'h0006, 1, 0, 0, 1, 1, 1, 12'h006, 0));
    tbl.push_back(mk(1, RE, 16'h0000, 1, 0, 0, 1, 0, 0, 12'h000, 0));
    tbl.push_back(mk(1, FE, 16'h0000, 1, 0, 0, 0, 0, 0, 12'h000, 0));
    mark(2, 3, 1);
    // Phase 2: implicit row start, left justify, last row closed by FRAME_END
    tbl.push_back(mk(1, FS, 16'h0000, 1, 1, 0, 1, 0, 0, 12'h000, 0));
    tbl.push_back(mk(1, PX, 16'hABC0, 1, 1, 0, 1, 1, 1, 12'hABC, 0));
    tbl.push_back(mk(1, PX, 16'hABD0, 1, 1, 0, 1, 1, 1, 12'hABD, 0));
    tbl.push_back(mk(1, RE, 16'h0000, 1, 1, 0, 1, 0, 0, 12'h000, 0));
    tbl.push_back(mk(1, RS, 16'h0000, 1, 1, 0, 1, 1, 0, 12'h000, 0));
    tbl.push_back(mk(1, PX, 16'h1230, 1, 1, 0, 1, 1, 1, 12'h123, 0));
    tbl.push_back(mk(1, RE, 16'h0000, 1, 1, 0, 1, 0, 0, 12'h000, 0));
    tbl.push_back(mk(1, RS, 16'h0000, 1, 0, 0, 1, 1, 0, 12'h000, 0));
    tbl.push_back(mk(1, PX, 16'hF011, 1, 0, 0, 1, 1, 1, 12'h011, 0));
    tbl.push_back(mk(1, PX, 16'hF012, 1, 0, 0, 1, 1, 1, 12'h012, 0));
    tbl.push_back(mk(1, PX, 16'hF013, 1, 0, 0, 1, 1, 1, 12'h013, 0));
    tbl.push_back(mk(1, PX, 16'hF014, 1, 0, 0, 1, 1, 1, 12'h014, 0));
    tbl.push_back(mk(1, FE, 16'h0000, 1, 0, 0, 0, 0, 0, 12'h000, 0));
    mark(3, 4, 2);
    // Phase 3: enable dropped mid-row 1 of a 4-row frame, then re-enabled mid-frame
    tbl.push_back(mk(1, FS, 16'h0000, 1, 0, 0, 1, 0, 0, 12'h000, 0));
    tbl.push_back(mk(1, RS, 16'h0000, 1, 0, 0, 1, 1, 0, 12'h000, 0));
    tbl.push_back(mk(1, PX, 16'h0021, 0, 0, 0, 1, 1, 1, 12'h021, 0));
    tbl.push_back(mk(1, RE, 16'h0000, 0, 0, 0, 1, 0, 0, 12'h000, 0));
    for (int r = 0; r < 3; r++) begin
      tbl.push_back(mk(1, RS, 16'h0000, 0, 0, 0, 1, 1, 0, 12'h000, 0));
      tbl.push_back(mk(1, PX, 16'h0022 + 16'(r), 0, 0, 0, 1, 1, 1, 12'h022 + 12'(r), 0));
      tbl.push_back(mk(1, RE, 16'h0000, 0, 0, 0, 1, 0, 0, 12'h000, 0));
    end
    tbl.push_back(mk(1, FE, 16'h0000, 0, 0, 0, 0, 0, 0, 12'h000, 0));
    mark(4, 1, 3);
    tbl.push_back(mk(1, FS, 16'h0000, 0, 0, 0, 0, 0, 0, 12'h000, 0));
    tbl.push_back(mk(1, RS, 16'h0000, 0, 0, 0, 0, 0, 0, 12'h000, 0));
    tbl.push_back(mk(1, PX, 16'h0025, 0, 0, 0, 0, 0, 0, 12'h000, 0));
    tbl.push_back(mk(1, PX, 16'h0026, 1, 0, 0, 0, 0, 0, 12'h000, 0));
    tbl.push_back(mk(1, RE, 16'h0000, 1, 0, 0, 0, 0, 0, 12'h000, 0));
    tbl.push_back(mk(1, FE, 16'h0000, 1, 0, 0, 0, 0, 0, 12'h000, 0));
    tbl.push_back(mk(1, FS, 16'h0000, 1, 0, 0, 1, 0, 0, 12'h000, 0));
    tbl.push_back(mk(1, FE, 16'h0000, 1, 0, 0, 0, 0, 0, 12'h000, 0));
    mark(0, -1, 4);
    // Phase 4: protocol errors and err_clr priority
    tbl.push_back(mk(1, FS, 16'h0000, 1, 0, 0, 1, 0, 0, 12'h000, 0));
    tbl.push_back(mk(1, RE, 16'h0000, 1, 0, 0, 1, 0, 0, 12'h000, 1));
    tbl.push_back(mk(0, PX, 16'h0000, 1, 0, 1, 1, 0, 0, 12'h000, 0));
    tbl.push_back(mk(1, RE, 16'h0000, 1, 0, 1, 1, 0, 0, 12'h000, 1));
    tbl.push_back(mk(1, RS, 16'h0000, 1, 0, 0, 1, 1, 0, 12'h000, 1));
    tbl.push_back(mk(1, FS, 16'h0000, 1, 0, 0, 1, 1, 0, 12'h000, 1));
    tbl.push_back(mk(1, RS, 16'h0000, 1, 0, 0, 1, 1, 0, 12'h000, 1));
    tbl.push_back(mk(1, PX, 16'h0007, 1, 0, 1, 1, 1, 1, 12'h007, 0));
    tbl.push_back(mk(1, HD, 16'h0999, 1, 0, 0, 1, 1, 0, 12'h000, 0));
    tbl.push_back(mk(1, FE, 16'h0000, 1, 0, 0, 0, 0, 0, 12'h000, 0));
    mark(1, 1, 5);
    // Phase 5: header block and a stray pixel between frames
    tbl.push_back(mk(1, HS, 16'h1111, 1, 0, 0, 0, 0, 0, 12'h000, 0));
    for (int h = 0; h < 10; h++)
      tbl.push_back(mk(1, HD, 16'h2000 + 16'(h), 1, 0, 0, 0, 0, 0, 12'h000, 0));
    tbl.push_back(mk(1, HE, 16'h3333, 1, 0, 0, 0, 0, 0, 12'h000, 0));
    tbl.push_back(mk(1, PX, 16'h0444, 1, 0, 0, 0, 0, 0, 12'h000, 0));
    mark(1, 1, 5);
    // Prefix for the async reset sequence
    tbl.push_back(mk(1, FS, 16'h0000, 1, 0, 0, 1, 0, 0, 12'h000, 0));
    tbl.push_back(mk(1, RS, 16'h0000, 1, 0, 0, 1, 1, 0, 12'h000, 0));
    tbl.push_back(mk(1, PX, 16'h0055, 1, 0, 0, 1, 1, 1, 12'h055, 0));

    resetb = 1'b0; enable = 1'b0; left_justify = 1'b0; dvi = 1'b0;
    dtypei = '0; datai = '0; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.fv", {31'd0, fv}, 32'd0);
    chk("rst.lv", {31'd0, lv}, 32'd0);
    chk("rst.dvo", {31'd0, dvo}, 32'd0);
    chk("rst.frame_count", {16'd0, frame_count}, 32'd0);
    chk("rst.num_rows", {16'd0, num_rows}, 32'd0);
    chk("rst.perr", {31'd0, protocol_err}, 32'd0);
    @(negedge clk);
    resetb = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Async reset asserted between clock edges while mid-line
    #2;
    resetb = 1'b0;
    #1;
    chk("arst.fv", {31'd0, fv}, 32'd0);
    chk("arst.lv", {31'd0, lv}, 32'd0);
    chk("arst.dvo", {31'd0, dvo}, 32'd0);
    chk("arst.datao", {20'd0, datao}, 32'd0);
    chk("arst.frame_count", {16'd0, frame_count}, 32'd0);
    $display("async reset mid-frame -> fv=%0d lv=%0d dvo=%0d fc=%0d", fv, lv, dvo, frame_count);
    @(negedge clk);
    dvi = 1'b0;
    resetb = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst.fv", {31'd0, fv}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imager_tx.md
Name: imager_tx

Overview:
Converts the internal image-pipeline stream (dv / dtype / data words with `DTYPE_* framing) back into a parallel sensor-style interface (fv, lv, dv, pixel data). It is the transmit-side counterpart of the imager receive block. It drives a downstream sensor-emulation port, a loopback into a receiver, or an external parallel video link. Header words are consumed and not emitted. Per-frame dimension and frame counters are kept for status readback.

Parameters:
PIXEL_WIDTH, 12, width of emitted pixel data.
DATA_WIDTH, 16, width of the pipeline data word; must be >= PIXEL_WIDTH.
DIM_WIDTH, 16, width of the row/column counters.

Ports:
clk  in  1  block clock; all logic on the rising edge.
resetb  in  1  asynchronous, active-low reset.
enable  in  1  transmit enable, synchronous to clk.
left_justify  in  1  1: pixel = datai[DATA_WIDTH-1 -: PIXEL_WIDTH]; 0: pixel = datai[PIXEL_WIDTH-1:0].
dvi  in  1  input word valid.
dtypei  in  `DTYPE_WIDTH  input word type.
datai  in  DATA_WIDTH  input word.
err_clr  in  1  clears protocol_err.
fv  out  1  frame valid.
lv  out  1  line valid.
dvo  out  1  pixel valid.
datao  out  PIXEL_WIDTH  pixel data.
num_rows  out  DIM_WIDTH  rows in the last completed frame.
num_cols  out  DIM_WIDTH  pixels in the last row of the last completed frame.
frame_count  out  16  number of frames started.
protocol_err  out  1  sticky framing-violation flag.

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0.
- Outputs are registered. An input word at cycle N affects the outputs at cycle N+1 (latency 1). Words with dvi=0 leave fv and lv unchanged and set dvo=0 and datao=0.
- States: IDLE (fv=0), FRAME (fv=1, lv=0), LINE (fv=1, lv=1).
- Transitions in IDLE:
  - FRAME_START with enable=1 -> FRAME; fv=1; frame_count+1; row_cnt=0.
  - Any other type is dropped silently.
- Transitions in FRAME:
  - ROW_START -> LINE; lv=1; col_cnt=0.
  - PIXEL -> implicit row start: LINE; lv=1; dvo=1 with that pixel; col_cnt=1. This covers the receiver suppressing ROW_START after FRAME_START.
  - FRAME_END -> IDLE; fv=0; num_rows<=row_cnt.
- Transitions in LINE:
  - PIXEL -> dvo=1; datao=pixel; col_cnt+1.
  - ROW_END -> FRAME; lv=0; row_cnt+1; last_cols<=col_cnt.
  - FRAME_END -> IDLE. lv and fv fall in the same cycle. Counts as a row: num_rows<=row_cnt+1; num_cols<=col_cnt.
  - A normal FRAME_END from FRAME sets num_cols<=last_cols.
- HEADER_START, HEADER and HEADER_END are ignored in every state, with no output change.
- Protocol errors set protocol_err. Each offending word is ignored and the state is unchanged.
  - FRAME_START in FRAME or LINE.
  - ROW_START in LINE.
  - ROW_END in FRAME.
- protocol_err clears on err_clr when no new error occurs in the same cycle; a new error wins.
- enable:
  - Sampled only in IDLE. Deassertion mid-frame does not truncate the frame; the block returns to IDLE at FRAME_END and then stays there.
  - Assertion mid-stream waits for the next FRAME_START. Partial frames are never emitted.
- Counters wrap modulo 2^width with no saturation.
- Back-to-back ROW_END then ROW_START gives an lv low gap of exactly 1 cycle.
- Asynchronous reset mid-frame: fv, lv and dvo drop immediately.

Optional Feature:
IMAGER_TX_TEST_PAT_EN
- Defined: adds input test_pat (1 bit). When test_pat=1, emitted pixel = (row_cnt + col_cnt) truncated to PIXEL_WIDTH, where col_cnt is the value before increment. datai is ignored for pixels; framing is unchanged.
- Undefined: port is absent; pixels always come from datai.

Test Plan:
- Frame of FRAME_START, 2 rows x 3 PIXEL (ROW_START/ROW_END each), FRAME_END, enable=1, left_justify=0, data 0x0001..0x0006:
  - fv high 1 cycle after FRAME_START; lv high twice, 3 dvo each; datao 1..6.
  - Afterwards num_rows=2, num_cols=3, frame_count=1.
- FRAME_START followed directly by PIXEL 0xABC0, left_justify=1, DATA_WIDTH=16, PIXEL_WIDTH=12: lv and dvo rise on the same cycle; datao=0xABC; protocol_err=0.
- Last row ends with FRAME_END (no ROW_END) after 4 pixels on row 3: fv and lv fall on the same cycle; num_rows=3; num_cols=4.
- enable dropped mid-row 1 of a 4-row frame: full frame still emitted. Next FRAME_START is ignored with fv=0. Re-enable mid-frame: no output until the following FRAME_START.
- ROW_END received in FRAME: protocol_err=1, lv stays 0. err_clr pulse -> protocol_err=0. Error and err_clr in the same cycle -> stays 1.
- HEADER_START, 10 HEADER words and HEADER_END inserted between frames: fv, lv and dvo remain 0; counters unchanged.
